// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: operand forwarding, load/branch/mul-div
// stalls, and a small FSM that tracks the multi-cycle mul/div unit with a watchdog.
module hazard_unit #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeRegE,
  input  logic [4:0]       writeRegM,
  input  logic [4:0]       writeRegW,
  input  logic             regWriteE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memToRegE,
  input  logic             memToRegM,
  input  logic             branchD,
  input  logic             mdReadD,
  input  logic             mdOpD,
  input  logic             mdStartE,
  input  logic             mdDone,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             mdBusy,
  output logic             mdTimeout,
  output logic [CNT_W-1:0] stallCnt
);

  localparam int BCNT_W = ($clog2(MD_TIMEOUT) + 1 > 8) ? $clog2(MD_TIMEOUT) + 1 : 8;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MD_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  md_state_t         state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              md_busy_q, md_busy_d;
  logic              md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic lw_stall, br_stall, md_stall, stall;

  // r0 is hardwired to zero, so a write to it never produces a dependency
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    if (rst) begin
      if (regWriteM && reg_hit(writeRegM, rsE))      forwardAE = 2'b10;
      else if (regWriteW && reg_hit(writeRegW, rsE)) forwardAE = 2'b01;
      if (regWriteM && reg_hit(writeRegM, rtE))      forwardBE = 2'b10;
      else if (regWriteW && reg_hit(writeRegW, rtE)) forwardBE = 2'b01;
      forwardAD = regWriteM && reg_hit(writeRegM, rsD);
      forwardBD = regWriteM && reg_hit(writeRegM, rtD);
    end
  end

  always_comb begin
    lw_stall = memToRegE && regWriteE &&
               (reg_hit(writeRegE, rsD) || reg_hit(writeRegE, rtD));
    br_stall = branchD &&
               ((regWriteE && (reg_hit(writeRegE, rsD) || reg_hit(writeRegE, rtD))) ||
                (memToRegM && (reg_hit(writeRegM, rsD) || reg_hit(writeRegM, rtD))));
    // mdStartE term closes the gap before the FSM registers BUSY
    md_stall = (mdReadD || mdOpD) && ((state_q == BUSY) || mdStartE);
    stall    = rst && (lw_stall || br_stall || md_stall);
  end

  assign stallF    = stall;
  assign stallD    = stall;
  assign flushE    = !rst || stall;
  assign mdBusy    = md_busy_q;
  assign mdTimeout = md_timeout_q;
  assign stallCnt  = stall_cnt_q;

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    md_timeout_d = md_timeout_q;
    case (state_q)
      IDLE: begin
        if (mdStartE) begin
          state_d = BUSY;
          bcnt_d  = '0;
        end
      end
      BUSY: begin
        if (mdStartE) begin
          bcnt_d = '0;
        end else if (mdDone) begin
          state_d = IDLE;
        end else if (bcnt_q == BCNT_LAST) begin
          state_d      = IDLE;
          md_timeout_d = 1'b1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    md_busy_d   = (state_d == BUSY);
    stall_cnt_d = (stallD && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      bcnt_q       <= '0;
      md_busy_q    <= 1'b0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      md_busy_q    <= md_busy_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a combinational vector table plus hand-written
// multi-cycle sequences (load-use, branch-after-load, mul/div, watchdog, reset).
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, branchD;
  logic mdReadD, mdOpD, mdStartE, mdDone;

  logic [1:0]  fAE_a, fBE_a, fAE_b, fBE_b;
  logic        fAD_a, fBD_a, fAD_b, fBD_b;
  logic        stallF_a, stallD_a, flushE_a, busy_a, tmo_a;
  logic        stallF_b, stallD_b, flushE_b, busy_b, tmo_b;
  logic [15:0] cnt_a, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit u_dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM), .branchD(branchD),
    .mdReadD(mdReadD), .mdOpD(mdOpD), .mdStartE(mdStartE), .mdDone(mdDone),
    .forwardAE(fAE_a), .forwardBE(fBE_a), .forwardAD(fAD_a), .forwardBD(fBD_a),
    .stallF(stallF_a), .stallD(stallD_a), .flushE(flushE_a),
    .mdBusy(busy_a), .mdTimeout(tmo_a), .stallCnt(cnt_a)
  );

  hazard_unit #(.MD_TIMEOUT(4), .CNT_W(16)) u_wd (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM), .branchD(branchD),
    .mdReadD(mdReadD), .mdOpD(mdOpD), .mdStartE(mdStartE), .mdDone(mdDone),
    .forwardAE(fAE_b), .forwardBE(fBE_b), .forwardAD(fAD_b), .forwardBD(fBD_b),
    .stallF(stallF_b), .stallD(stallD_b), .flushE(flushE_b),
    .mdBusy(busy_b), .mdTimeout(tmo_b), .stallCnt(cnt_b)
  );

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, mtE, mtM, brD;
    logic [1:0] fAE, fBE;
    logic       fAD, fBD, stall;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
    {regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, branchD} = '0;
    {mdReadD, mdOpD, mdStartE, mdDone} = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  vec_t vecs[13];

  initial begin
    // rsD rtD rsE rtE wE wM wW  rwE rwM rwW mtE mtM brD  fAE fBE fAD fBD stall
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0};
    vecs[1]  = '{5, 0, 0, 0, 5, 0, 0,  1, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 1};
    vecs[2]  = '{5, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1,  2'b00, 2'b00, 0, 0, 0};
    vecs[4]  = '{0, 0, 3, 0, 0, 3, 3,  0, 1, 1, 0, 0, 0,  2'b10, 2'b00, 0, 0, 0};
    vecs[5]  = '{0, 0, 3, 0, 0, 3, 3,  0, 0, 1, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 9, 0, 2, 9,  0, 1, 1, 0, 0, 0,  2'b00, 2'b01, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0};
    vecs[8]  = '{4, 4, 0, 0, 0, 4, 0,  0, 1, 0, 0, 0, 0,  2'b00, 2'b00, 1, 1, 0};
    vecs[9]  = '{0, 6, 0, 0, 6, 0, 0,  1, 0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 1};
    vecs[10] = '{7, 0, 0, 0, 0, 7, 0,  0, 0, 0, 0, 1, 1,  2'b00, 2'b00, 0, 0, 1};
    vecs[11] = '{7, 0, 0, 0, 0, 7, 0,  0, 0, 0, 0, 1, 0,  2'b00, 2'b00, 0, 0, 0};
    vecs[12] = '{0, 8, 0, 0, 8, 0, 0,  0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0};

    clear_inputs();
    rst = 1'b0;
    // Matching forward/stall inputs during reset must be masked.
    rsE = 5'd3; writeRegM = 5'd3; regWriteM = 1'b1;
    memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd5; rsD = 5'd5;
    next_cycle();
    next_cycle();
    #2;
    chk("rst_busy", busy_a, 0);
    chk("rst_tmo", tmo_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_flushE", flushE_a, 1);
    chk("rst_stallF", stallF_a, 0);
    chk("rst_stallD", stallD_a, 0);
    chk("rst_fAE", fAE_a, 0);
    chk("rst_fAD", fAD_a, 0);
    clear_inputs();
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      rsD = vecs[i].rsD; rtD = vecs[i].rtD; rsE = vecs[i].rsE; rtE = vecs[i].rtE;
      writeRegE = vecs[i].wE; writeRegM = vecs[i].wM; writeRegW = vecs[i].wW;
      regWriteE = vecs[i].rwE; regWriteM = vecs[i].rwM; regWriteW = vecs[i].rwW;
      memToRegE = vecs[i].mtE; memToRegM = vecs[i].mtM; branchD = vecs[i].brD;
      #2;
      chk($sformatf("v%0d_fAE", i), fAE_a, vecs[i].fAE);
      chk($sformatf("v%0d_fBE", i), fBE_a, vecs[i].fBE);
      chk($sformatf("v%0d_fAD", i), fAD_a, vecs[i].fAD);
      chk($sformatf("v%0d_fBD", i), fBD_a, vecs[i].fBD);
      chk($sformatf("v%0d_stallF", i), stallF_a, vecs[i].stall);
      chk($sformatf("v%0d_stallD", i), stallD_a, vecs[i].stall);
      chk($sformatf("v%0d_flushE", i), flushE_a, vecs[i].stall);
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    // Load-use: one bubble, then the load sits in MEM and decode proceeds.
    rsD = 5'd5; memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd5;
    #2;
    chk("lu_c0_stall", stallD_a, 1);
    next_cycle();
    memToRegE = 1'b0; regWriteE = 1'b0; writeRegE = 5'd0;
    memToRegM = 1'b1; regWriteM = 1'b1; writeRegM = 5'd5;
    #2;
    chk("lu_c1_stall", stallD_a, 0);
    chk("lu_c1_flushE", flushE_a, 0);
    next_cycle();
    clear_inputs();

    // Branch on a load result: stalled with the load in EX and again in MEM.
    branchD = 1'b1; rtD = 5'd7;
    memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd7;
    #2;
    chk("bl_c0_stall", stallD_a, 1);
    next_cycle();
    memToRegE = 1'b0; regWriteE = 1'b0; writeRegE = 5'd0;
    memToRegM = 1'b1; regWriteM = 1'b1; writeRegM = 5'd7;
    #2;
    chk("bl_c1_stall", stallD_a, 1);
    next_cycle();
    memToRegM = 1'b0; regWriteM = 1'b0; writeRegM = 5'd0;
    regWriteW = 1'b1; writeRegW = 5'd7;
    #2;
    chk("bl_c2_stall", stallD_a, 0);
    chk("bl_c2_fBD", fBD_a, 0);
    next_cycle();
    clear_inputs();

    // Mul/div: start, 10 busy cycles with mdDone in the 10th, 11 stalled edges.
    do_reset();
    mdStartE = 1'b1; mdReadD = 1'b1;
    #2;
    chk("md_c0_stall", stallD_a, 1);
    chk("md_c0_busy", busy_a, 0);
    next_cycle();
    mdStartE = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      mdDone = (c == 10);
      #2;
      if (c == 1 || c == 10) begin
        chk($sformatf("md_c%0d_busy", c), busy_a, 1);
        chk($sformatf("md_c%0d_stall", c), stallD_a, 1);
      end
      next_cycle();
    end
    mdDone = 1'b0;
    #2;
    chk("md_c11_busy", busy_a, 0);
    chk("md_c11_stall", stallD_a, 0);
    chk("md_c11_cnt", cnt_a, 11);
    chk("md_c11_tmo", tmo_a, 0);
    clear_inputs();
    next_cycle();

    // Watchdog (MD_TIMEOUT=4 instance): busy exactly 4 cycles, sticky flag.
    do_reset();
    mdStartE = 1'b1;
    next_cycle();
    mdStartE = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #2;
      chk($sformatf("wd_c%0d_busy", c), busy_b, 1);
      chk($sformatf("wd_c%0d_tmo", c), tmo_b, 0);
      next_cycle();
    end
    #2;
    chk("wd_c5_busy", busy_b, 0);
    chk("wd_c5_tmo", tmo_b, 1);
    chk("wd_c5_dflt_tmo", tmo_a, 0);
    mdDone = 1'b1;
    next_cycle();
    mdDone = 1'b0;
    #2;
    chk("wd_c6_busy", busy_b, 0);
    chk("wd_c6_tmo", tmo_b, 1);
    next_cycle();
    #2;
    chk("wd_c7_tmo", tmo_b, 1);
    clear_inputs();

    // Reset mid-BUSY discards tracking; flushE held high while rst is low.
    mdStartE = 1'b1; mdReadD = 1'b1;
    next_cycle();
    mdStartE = 1'b0;
    next_cycle();
    rst = 1'b0;
    #2;
    chk("rb_pre_busy", busy_a, 1);
    chk("rb_pre_cnt", cnt_a, 2);
    chk("rb_flushE", flushE_a, 1);
    chk("rb_stallD", stallD_a, 0);
    next_cycle();
    rst = 1'b1;
    mdReadD = 1'b0;
    #2;
    chk("rb_busy", busy_a, 0);
    chk("rb_cnt", cnt_a, 0);
    chk("rb_wd_tmo", tmo_b, 0);
    chk("rb_wd_busy", busy_b, 0);
    chk("rb_flushE_off", flushE_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
